// File: rtl/wb_axil_bridge_v2.sv
// Wishbone-classic target to AXI4-Lite master bridge with response timeout,
// hung-slave lockout and a saturating error counter.
//
// state | meaning
// IDLE  | waiting for wb_cyc_i & wb_stb_i, timeout counter cleared
// ADDR  | AW+W (write) or AR (read) valids presented
// RESP  | bready/rready high, waiting for B or R
// TERM  | one-cycle wb_ack_o or wb_err_o
// HUNG  | timed out; draining outstanding AXI handshakes, WB answered with err
module wb_axil_bridge_v2 #(
  parameter int ADDR_BITS      = 18,
  parameter int DATA_BITS      = 32,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int ERRCNT_BITS    = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [ADDR_BITS-1:0]     wb_adr_i,
  input  logic [DATA_BITS-1:0]     wb_dat_i,
  input  logic [DATA_BITS/8-1:0]   wb_sel_i,
  output logic [DATA_BITS-1:0]     wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     wb_rty_o,
  output logic [ADDR_BITS-1:0]     m_axi_awaddr,
  output logic [2:0]               m_axi_awprot,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [DATA_BITS-1:0]     m_axi_wdata,
  output logic [DATA_BITS/8-1:0]   m_axi_wstrb,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic [ADDR_BITS-1:0]     m_axi_araddr,
  output logic [2:0]               m_axi_arprot,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [DATA_BITS-1:0]     m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready,
  output logic                     bridge_err_o,
  output logic                     timeout_o,
  output logic [ERRCNT_BITS-1:0]   err_count_o
);

  localparam int SEL_BITS = DATA_BITS / 8;
  localparam int CNT_BITS = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, RESP, TERM, HUNG} state_t;
  state_t state, state_nxt;

  logic                   we_q;
  logic [ADDR_BITS-1:0]   adr_q;
  logic [DATA_BITS-1:0]   dat_q;
  logic [SEL_BITS-1:0]    sel_q;
  logic [DATA_BITS-1:0]   rdata_q;
  logic                   aw_done, w_done, ar_done, resp_done;
  logic                   err_pending, hung_err;
  logic [CNT_BITS-1:0]    tmo_cnt;
  logic [ERRCNT_BITS-1:0] err_cnt;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic aw_all, w_all, ar_all, resp_all, addr_fin, advance, tmo_fire, wb_req;

  assign wb_req        = wb_cyc_i & wb_stb_i;
  assign m_axi_awaddr  = adr_q;
  assign m_axi_araddr  = adr_q;
  assign m_axi_wdata   = dat_q;
  assign m_axi_wstrb   = sel_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign wb_rty_o      = 1'b0;
  assign wb_dat_o      = rdata_q;
  assign err_count_o   = err_cnt;

  always_comb begin
    m_axi_awvalid = (state == ADDR || state == HUNG) && we_q && !aw_done;
    m_axi_wvalid  = (state == ADDR || state == HUNG) && we_q && !w_done;
    m_axi_arvalid = (state == ADDR || state == HUNG) && !we_q && !ar_done;
    m_axi_bready  = (state == RESP || state == HUNG) && we_q && !resp_done;
    m_axi_rready  = (state == RESP || state == HUNG) && !we_q && !resp_done;

    aw_hs    = m_axi_awvalid & m_axi_awready;
    w_hs     = m_axi_wvalid & m_axi_wready;
    ar_hs    = m_axi_arvalid & m_axi_arready;
    b_hs     = m_axi_bvalid & m_axi_bready;
    r_hs     = m_axi_rvalid & m_axi_rready;
    aw_all   = aw_done | aw_hs;
    w_all    = w_done | w_hs;
    ar_all   = ar_done | ar_hs;
    resp_all = resp_done | b_hs | r_hs;
    addr_fin = we_q ? (aw_all & w_all) : ar_all;
    advance  = ((state == ADDR) && addr_fin) || ((state == RESP) && (b_hs || r_hs));
    // a handshake landing on the expiry cycle wins over the timeout
    tmo_fire = (TIMEOUT_CYCLES != 0) && (state == ADDR || state == RESP) &&
               (tmo_cnt == CNT_BITS'(TIMEOUT_CYCLES)) && !advance;

    timeout_o    = tmo_fire;
    wb_ack_o     = (state == TERM) && !err_pending;
    wb_err_o     = ((state == TERM) && err_pending) || tmo_fire || hung_err;
    bridge_err_o = wb_err_o;

    state_nxt = state;
    case (state)
      IDLE: if (wb_req) state_nxt = ADDR;
      ADDR: begin
        if (tmo_fire)      state_nxt = HUNG;
        else if (addr_fin) state_nxt = RESP;
      end
      RESP: begin
        if (tmo_fire)          state_nxt = HUNG;
        else if (b_hs || r_hs) state_nxt = TERM;
      end
      TERM: state_nxt = IDLE;
      HUNG: if (addr_fin && resp_all && !hung_err && !wb_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rdata_q     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      ar_done     <= 1'b0;
      resp_done   <= 1'b0;
      err_pending <= 1'b0;
      hung_err    <= 1'b0;
      tmo_cnt     <= '0;
      err_cnt     <= '0;
    end else begin
      state    <= state_nxt;
      hung_err <= (state == HUNG) && wb_req && !hung_err;
      if (wb_err_o && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      case (state)
        IDLE: begin
          tmo_cnt     <= '0;
          aw_done     <= 1'b0;
          w_done      <= 1'b0;
          ar_done     <= 1'b0;
          resp_done   <= 1'b0;
          err_pending <= 1'b0;
          if (wb_req) begin
            we_q  <= wb_we_i;
            adr_q <= wb_adr_i;
            dat_q <= wb_dat_i;
            sel_q <= wb_sel_i;
          end
        end
        ADDR, RESP, HUNG: begin
          aw_done   <= aw_all;
          w_done    <= w_all;
          ar_done   <= ar_all;
          resp_done <= resp_all;
          if (state != HUNG && TIMEOUT_CYCLES != 0) tmo_cnt <= tmo_cnt + 1'b1;
          // late responses arriving in HUNG are drained but never reach WB
          if (state == RESP && (b_hs || r_hs)) begin
            err_pending <= we_q ? m_axi_bresp[1] : m_axi_rresp[1];
            if (r_hs) rdata_q <= m_axi_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_axil_bridge_v2.sv
// Self-checking bench for wb_axil_bridge_v2: AXI-Lite slave model with programmable
// delays and a transaction-level reference model for latency, termination and data.
module tb_wb_axil_bridge_v2;
  localparam int AW = 18, DW = 32, SW = 4, EW = 8, TMO = 16;

  logic aclk = 1'b0, aresetn = 1'b0;
  logic wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [AW-1:0] wb_adr_i = '0;
  logic [DW-1:0] wb_dat_i = '0;
  logic [SW-1:0] wb_sel_i = '0;
  logic [DW-1:0] wb_dat_o;
  logic wb_ack_o, wb_err_o, wb_rty_o;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0] m_axi_awprot, m_axi_arprot;
  logic m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [DW-1:0] m_axi_wdata;
  logic [SW-1:0] m_axi_wstrb;
  logic [1:0] m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
  logic [DW-1:0] m_axi_rdata = '0;
  logic bridge_err_o, timeout_o;
  logic [EW-1:0] err_count_o;

  wb_axil_bridge_v2 #(.ADDR_BITS(AW), .DATA_BITS(DW), .TIMEOUT_CYCLES(TMO), .ERRCNT_BITS(EW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .bridge_err_o(bridge_err_o), .timeout_o(timeout_o),
    .err_count_o(err_count_o)
  );

  always #5 aclk = ~aclk;

  // slave behaviour knobs
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic hang_b = 1'b0;
  logic [1:0] s_bresp = 2'b00, s_rresp = 2'b00;
  logic [DW-1:0] s_rdata = '0;
  // slave state / monitor
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  logic got_aw = 1'b0, got_w = 1'b0, got_ar = 1'b0;
  logic aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
  int aw_beats = 0, w_beats = 0, ar_beats = 0, b_beats = 0, r_beats = 0, proto_err = 0;
  logic [AW-1:0] s_awaddr = '0, s_araddr = '0;
  logic [DW-1:0] s_wdata = '0;
  logic [SW-1:0] s_wstrb = '0;

  int n_cmp = 0, n_bad = 0;
  int exp_errcnt = 0;
  logic [DW-1:0] exp_dat = '0;

  // Slave decides readies/valids at negedge; the DUT's valids/readies are
  // register-decoded so they are stable until the next posedge handshake.
  always @(negedge aclk) begin
    if (!aresetn) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
      m_axi_bvalid = 0; m_axi_rvalid = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      got_aw = 0; got_w = 0; got_ar = 0; aw_pend = 0; w_pend = 0; ar_pend = 0;
    end else begin
      if (got_aw && got_w && !hang_b) begin
        if (b_cnt >= b_delay) m_axi_bvalid = 1;
        else begin m_axi_bvalid = 0; b_cnt++; end
      end else m_axi_bvalid = 0;
      m_axi_bresp = s_bresp;
      if (m_axi_bvalid && m_axi_bready) begin b_beats++; got_aw = 0; got_w = 0; b_cnt = 0; end

      if (got_ar) begin
        if (r_cnt >= r_delay) m_axi_rvalid = 1;
        else begin m_axi_rvalid = 0; r_cnt++; end
      end else m_axi_rvalid = 0;
      m_axi_rresp = s_rresp;
      m_axi_rdata = s_rdata;
      if (m_axi_rvalid && m_axi_rready) begin r_beats++; got_ar = 0; r_cnt = 0; end

      if (aw_pend && !m_axi_awvalid) proto_err++;
      if (w_pend && !m_axi_wvalid) proto_err++;
      if (ar_pend && !m_axi_arvalid) proto_err++;

      if (m_axi_awvalid) begin
        if (aw_cnt >= aw_delay) begin
          m_axi_awready = 1; aw_beats++; got_aw = 1; s_awaddr = m_axi_awaddr; aw_cnt = 0;
        end else begin m_axi_awready = 0; aw_cnt++; end
      end else begin m_axi_awready = 0; aw_cnt = 0; end
      if (m_axi_wvalid) begin
        if (w_cnt >= w_delay) begin
          m_axi_wready = 1; w_beats++; got_w = 1; s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb;
          w_cnt = 0;
        end else begin m_axi_wready = 0; w_cnt++; end
      end else begin m_axi_wready = 0; w_cnt = 0; end
      if (m_axi_arvalid) begin
        if (ar_cnt >= ar_delay) begin
          m_axi_arready = 1; ar_beats++; got_ar = 1; s_araddr = m_axi_araddr; ar_cnt = 0;
        end else begin m_axi_arready = 0; ar_cnt++; end
      end else begin m_axi_arready = 0; ar_cnt = 0; end
      aw_pend = m_axi_awvalid && !m_axi_awready;
      w_pend  = m_axi_wvalid && !m_axi_wready;
      ar_pend = m_axi_arvalid && !m_axi_arready;
    end
  end

  // Drives one WB cycle from posedge+1; returns at posedge+1 after termination.
  task automatic wb_xfer(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel, output logic g_ack, output logic g_err,
                         output logic g_tmo, output logic g_berr, output int lat);
    wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    wb_cyc_i = 1; wb_stb_i = 1;
    lat = 0; g_ack = 0; g_err = 0; g_tmo = 0; g_berr = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge aclk); #1;
      if (wb_ack_o || wb_err_o) begin
        lat = k; g_ack = wb_ack_o; g_err = wb_err_o; g_tmo = timeout_o; g_berr = bridge_err_o;
        break;
      end
    end
    wb_cyc_i = 0; wb_stb_i = 0;
    n_cmp++;
    if (lat == 0) begin n_bad++; $display("FAIL xfer_bound: no termination within 60 cycles, required one"); end
    n_cmp++;
    if (g_ack && g_err) begin n_bad++; $display("FAIL ack_err_excl: ack=%0b err=%0b, required not both", g_ack, g_err); end
    @(posedge aclk); #1;
  endtask

  function automatic int bump(input int c);
    return (c < 255) ? c + 1 : 255;
  endfunction

  task automatic test_reset();
    #17;
    n_cmp++;
    if ((|{wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
           m_axi_arvalid, m_axi_rready, bridge_err_o, timeout_o, err_count_o,
           m_axi_awaddr, m_axi_wdata, m_axi_wstrb}) !== 1'b0) begin
      n_bad++; $display("FAIL reset_outputs: some output nonzero (dat=%h cnt=%0d), required all 0", wb_dat_o, err_count_o);
    end
    aresetn = 1;
    @(posedge aclk); #1;
  endtask

  task automatic test_basic_write();
    logic a, e, t, be; int lat; int aw0, w0, b0;
    aw_delay = 0; w_delay = 0; b_delay = 0; s_bresp = 2'b00;
    aw0 = aw_beats; w0 = w_beats; b0 = b_beats;
    wb_xfer(1, 18'h00104, 32'hDEADBEEF, 4'hF, a, e, t, be, lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL wr_latency: got %0d want 4", lat); end
    n_cmp++; if ({a, e, be} !== 3'b100) begin n_bad++; $display("FAIL wr_term: ack/err/berr=%b want 100", {a, e, be}); end
    n_cmp++; if (s_awaddr !== 18'h00104) begin n_bad++; $display("FAIL wr_awaddr: got %h want 00104", s_awaddr); end
    n_cmp++; if ({s_wdata, s_wstrb} !== {32'hDEADBEEF, 4'hF}) begin n_bad++; $display("FAIL wr_wbeat: got %h/%h want deadbeef/f", s_wdata, s_wstrb); end
    n_cmp++; if ((aw_beats - aw0) + (w_beats - w0) + (b_beats - b0) !== 3) begin n_bad++; $display("FAIL wr_beats: got %0d want 3", (aw_beats - aw0) + (w_beats - w0) + (b_beats - b0)); end
    n_cmp++; if (err_count_o !== 8'd0) begin n_bad++; $display("FAIL wr_errcnt: got %0d want 0", err_count_o); end
  endtask

  task automatic test_split_write();
    logic a, e, t, be; int lat; int aw0, w0;
    aw_delay = 3; w_delay = 0; b_delay = 0; s_bresp = 2'b00;
    aw0 = aw_beats; w0 = w_beats;
    wb_xfer(1, 18'h00208, 32'hCAFEF00D, 4'h3, a, e, t, be, lat);
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL split_latency: got %0d want 7", lat); end
    n_cmp++; if ({a, e} !== 2'b10) begin n_bad++; $display("FAIL split_term: ack/err=%b want 10", {a, e}); end
    n_cmp++; if ({aw_beats - aw0, w_beats - w0} !== {32'd1, 32'd1}) begin n_bad++; $display("FAIL split_beats: aw=%0d w=%0d want 1/1", aw_beats - aw0, w_beats - w0); end
    n_cmp++; if (proto_err !== 0) begin n_bad++; $display("FAIL split_valid_drop: got %0d want 0", proto_err); end
    aw_delay = 0;
  endtask

  task automatic test_read_slverr();
    logic a, e, t, be; int lat;
    ar_delay = 0; r_delay = 0; s_rdata = 32'h12345678; s_rresp = 2'b10;
    wb_xfer(0, 18'h00200, '0, 4'hF, a, e, t, be, lat);
    exp_errcnt = bump(exp_errcnt); exp_dat = 32'h12345678;
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL rd_latency: got %0d want 4", lat); end
    n_cmp++; if ({a, e, be} !== 3'b011) begin n_bad++; $display("FAIL rd_term: ack/err/berr=%b want 011", {a, e, be}); end
    n_cmp++; if (wb_dat_o !== exp_dat) begin n_bad++; $display("FAIL rd_data: got %h want %h", wb_dat_o, exp_dat); end
    n_cmp++; if (s_araddr !== 18'h00200) begin n_bad++; $display("FAIL rd_araddr: got %h want 00200", s_araddr); end
    n_cmp++; if (err_count_o !== EW'(exp_errcnt)) begin n_bad++; $display("FAIL rd_errcnt: got %0d want %0d", err_count_o, exp_errcnt); end
    s_rresp = 2'b00;
  endtask

  task automatic test_random();
    logic a, e, t, be; int lat, exp_lat; logic we; logic [AW-1:0] adr;
    logic [DW-1:0] dat; logic [SW-1:0] sel; logic [1:0] resp;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1)); adr = AW'($urandom); dat = $urandom; sel = SW'($urandom);
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
      resp = 2'($urandom_range(0, 3)); s_bresp = resp; s_rresp = resp; s_rdata = $urandom;
      exp_lat = we ? 1 + ((aw_delay > w_delay ? aw_delay : w_delay) + 1) + (b_delay + 1) + 1
                   : 1 + (ar_delay + 1) + (r_delay + 1) + 1;
      wb_xfer(we, adr, dat, sel, a, e, t, be, lat);
      if (resp[1]) exp_errcnt = bump(exp_errcnt);
      if (!we) exp_dat = s_rdata;
      n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, exp_lat); end
      n_cmp++; if ({a, e, be, t} !== {~resp[1], resp[1], resp[1], 1'b0}) begin n_bad++; $display("FAIL rnd_term[%0d]: ack/err/berr/tmo=%b want %b", i, {a, e, be, t}, {~resp[1], resp[1], resp[1], 1'b0}); end
      n_cmp++; if (wb_dat_o !== exp_dat) begin n_bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, wb_dat_o, exp_dat); end
      if (we) begin
        n_cmp++; if ({s_awaddr, s_wdata, s_wstrb} !== {adr, dat, sel}) begin n_bad++; $display("FAIL rnd_wbeat[%0d]: got %h/%h/%h want %h/%h/%h", i, s_awaddr, s_wdata, s_wstrb, adr, dat, sel); end
      end else begin
        n_cmp++; if (s_araddr !== adr) begin n_bad++; $display("FAIL rnd_araddr[%0d]: got %h want %h", i, s_araddr, adr); end
      end
      n_cmp++; if (err_count_o !== EW'(exp_errcnt)) begin n_bad++; $display("FAIL rnd_errcnt[%0d]: got %0d want %0d", i, err_count_o, exp_errcnt); end
    end
    n_cmp++; if (proto_err !== 0) begin n_bad++; $display("FAIL rnd_valid_drop: got %0d want 0", proto_err); end
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0; s_bresp = 0; s_rresp = 0;
  endtask

  task automatic test_timeout_boundary();
    logic a, e, t, be; int lat; int b0;
    // ADDR 1 cycle + RESP 16 cycles: handshake lands exactly on expiry
    b_delay = 15;
    wb_xfer(1, 18'h00010, 32'h1, 4'hF, a, e, t, be, lat);
    n_cmp++; if ({lat, a, e, t} !== {32'd19, 3'b100}) begin n_bad++; $display("FAIL tmo_edge_ok: lat=%0d ack/err/tmo=%b want 19/100", lat, {a, e, t}); end
    b_delay = 16; b0 = b_beats;
    wb_xfer(1, 18'h00014, 32'h2, 4'hF, a, e, t, be, lat);
    exp_errcnt = bump(exp_errcnt);
    n_cmp++; if ({lat, a, e, t} !== {32'd18, 3'b011}) begin n_bad++; $display("FAIL tmo_edge_fire: lat=%0d ack/err/tmo=%b want 18/011", lat, {a, e, t}); end
    repeat (3) @(posedge aclk); #1;
    n_cmp++; if (b_beats - b0 !== 1) begin n_bad++; $display("FAIL tmo_late_b: got %0d want 1", b_beats - b0); end
    n_cmp++; if (err_count_o !== EW'(exp_errcnt)) begin n_bad++; $display("FAIL tmo_errcnt: got %0d want %0d", err_count_o, exp_errcnt); end
    b_delay = 0;
  endtask

  task automatic test_hung();
    logic a, e, t, be; int lat; int ar0, b0;
    hang_b = 1; b0 = b_beats;
    wb_xfer(1, 18'h00300, 32'hA5A5A5A5, 4'hF, a, e, t, be, lat);
    exp_errcnt = bump(exp_errcnt);
    n_cmp++; if ({lat, a, e, t, be} !== {32'd18, 4'b0111}) begin n_bad++; $display("FAIL hung_timeout: lat=%0d ack/err/tmo/berr=%b want 18/0111", lat, {a, e, t, be}); end
    ar0 = ar_beats; s_rdata = 32'h0BADF00D;
    wb_xfer(0, 18'h00304, '0, 4'hF, a, e, t, be, lat);
    exp_errcnt = bump(exp_errcnt);
    n_cmp++; if ({lat, a, e, t} !== {32'd2, 3'b010}) begin n_bad++; $display("FAIL hung_rd_err: lat=%0d ack/err/tmo=%b want 2/010", lat, {a, e, t}); end
    n_cmp++; if (ar_beats - ar0 !== 0 || m_axi_arvalid !== 1'b0) begin n_bad++; $display("FAIL hung_no_ar: beats=%0d arvalid=%b want 0/0", ar_beats - ar0, m_axi_arvalid); end
    n_cmp++; if (m_axi_bready !== 1'b1) begin n_bad++; $display("FAIL hung_bready: got %b want 1", m_axi_bready); end
    n_cmp++; if (err_count_o !== EW'(exp_errcnt)) begin n_bad++; $display("FAIL hung_errcnt: got %0d want %0d", err_count_o, exp_errcnt); end
    hang_b = 0;
    repeat (3) @(posedge aclk); #1;
    n_cmp++; if (b_beats - b0 !== 1) begin n_bad++; $display("FAIL hung_late_b: got %0d want 1", b_beats - b0); end
    s_rdata = 32'h600DCAFE; s_rresp = 2'b00;
    wb_xfer(0, 18'h00308, '0, 4'hF, a, e, t, be, lat);
    exp_dat = 32'h600DCAFE;
    n_cmp++; if ({lat, a, e} !== {32'd4, 2'b10}) begin n_bad++; $display("FAIL hung_recover: lat=%0d ack/err=%b want 4/10", lat, {a, e}); end
    n_cmp++; if (wb_dat_o !== exp_dat) begin n_bad++; $display("FAIL hung_recover_data: got %h want %h", wb_dat_o, exp_dat); end
  endtask

  task automatic test_saturate();
    logic a, e, t, be; int lat;
    s_rresp = 2'b10;
    for (int i = 0; i < 260; i++) begin
      s_rdata = $urandom;
      wb_xfer(0, AW'(i * 4), '0, 4'hF, a, e, t, be, lat);
      exp_errcnt = bump(exp_errcnt);
      n_cmp++; if (err_count_o !== EW'(exp_errcnt)) begin n_bad++; $display("FAIL sat_step[%0d]: got %0d want %0d", i, err_count_o, exp_errcnt); end
    end
    n_cmp++; if (err_count_o !== 8'd255) begin n_bad++; $display("FAIL sat_final: got %0d want 255", err_count_o); end
    s_rresp = 2'b00;
  endtask

  task automatic test_async_reset();
    logic a, e, t, be; int lat;
    ar_delay = 0; r_delay = 5; s_rdata = 32'h77777777;
    wb_we_i = 0; wb_adr_i = 18'h00400; wb_cyc_i = 1; wb_stb_i = 1;
    repeat (3) @(negedge aclk); #1;
    n_cmp++; if (m_axi_rready !== 1'b1) begin n_bad++; $display("FAIL arst_in_resp: rready=%b want 1", m_axi_rready); end
    aresetn = 0; #1;
    n_cmp++;
    if ((|{wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
           m_axi_arvalid, m_axi_rready, bridge_err_o, timeout_o, err_count_o,
           m_axi_araddr, m_axi_wdata}) !== 1'b0) begin
      n_bad++; $display("FAIL arst_outputs: dat=%h cnt=%0d rready=%b, required all 0", wb_dat_o, err_count_o, m_axi_rready);
    end
    wb_cyc_i = 0; wb_stb_i = 0;
    @(negedge aclk); @(posedge aclk); #3;
    aresetn = 1; exp_errcnt = 0; exp_dat = '0; r_delay = 0;
    @(posedge aclk); #1;
    aw_delay = 0; w_delay = 0; b_delay = 0; s_bresp = 0;
    wb_xfer(1, 18'h00500, 32'h13572468, 4'hC, a, e, t, be, lat);
    n_cmp++; if ({lat, a, e} !== {32'd4, 2'b10}) begin n_bad++; $display("FAIL arst_recover: lat=%0d ack/err=%b want 4/10", lat, {a, e}); end
    n_cmp++; if ({err_count_o, wb_dat_o} !== {8'd0, 32'd0}) begin n_bad++; $display("FAIL arst_regs: cnt=%0d dat=%h want 0/0", err_count_o, wb_dat_o); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_write();
    test_split_write();
    test_read_slverr();
    test_random();
    test_timeout_boundary();
    test_hung();
    test_saturate();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_axil_bridge_v2.md
Name: wb_axil_bridge_v2

Overview:
Parametrised Wishbone-classic target to AXI4-Lite master bridge. It is the single-clock successor to the RFDC register bridge, for use in front of any AXI4-Lite IP core (RFDC, SYSMON, etc.). It adds the following over the first-generation bridge:
- generic address/data widths
- registered read data
- AXI SLVERR/DECERR mapped to wb_err_o
- a response timeout, with a lockout state for hung slaves
- a saturating error counter

Parameters:
ADDR_BITS, 18, width of wb_adr_i / awaddr / araddr
DATA_BITS, 32, data width (32 or 64); strobe width is DATA_BITS/8
TIMEOUT_CYCLES, 1023, cycles allowed from leaving IDLE to the AXI response; 0 disables the timeout
ERRCNT_BITS, 8, width of the saturating error counter

Ports:
aclk  in  1  bridge clock (Wishbone and AXI side)
aresetn  in  1  asynchronous active-low reset
wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic cycle/strobe/write
wb_adr_i  in  ADDR_BITS  address
wb_dat_i  in  DATA_BITS  write data
wb_sel_i  in  DATA_BITS/8  byte selects
wb_dat_o  out  DATA_BITS  registered read data
wb_ack_o, wb_err_o, wb_rty_o  out  1 each  termination (wb_rty_o tied 0)
m_axi_aw*/w*/b*/ar*/r*  -  per AXI4-Lite  AXI4-Lite master: addr ADDR_BITS, data DATA_BITS, prot tied 3'b000
bridge_err_o  out  1  one-cycle pulse on any error termination
timeout_o  out  1  one-cycle pulse when the timeout fires
err_count_o  out  ERRCNT_BITS  saturating count of error terminations

Behaviour:
Reset (aresetn low, asynchronous): every output is 0, including:
- all AXI valid/ready signals
- wb_dat_o and err_count_o
- state = IDLE, timeout counter = 0

Deassertion of reset is sampled synchronously.

State machine:
- IDLE: on wb_cyc_i & wb_stb_i, latch we/adr/dat/sel and go to ADDR. The timeout counter is cleared.
- ADDR, write: awvalid and wvalid are asserted together; each deasserts independently on its own ready (flags aw_done/w_done). Go to RESP once both are done, including when both complete in the same cycle.
- ADDR, read: arvalid is held until arready, then go to RESP.
- RESP: bready (write) or rready (read) is held high.
  - On the handshake, rdata is registered into wb_dat_o (reads only); resp[1] sets err_pending.
  - Go to TERM.
- TERM: one cycle of wb_ack_o = !err_pending or wb_err_o = err_pending, never both. Then go to IDLE. The master must drop stb in that cycle.
- Timeout (TIMEOUT_CYCLES != 0): the counter increments in ADDR/RESP.
  - When it reaches TIMEOUT_CYCLES with no completing handshake in that cycle: pulse timeout_o, assert wb_err_o for one cycle, go to HUNG.
  - A handshake in the same cycle as expiry takes priority (normal path, no timeout).
- HUNG:
  - Any pending valids are kept asserted (AXI forbids withdrawing them). bready/rready are high for the outstanding channel.
  - Any new WB cycle is answered with wb_err_o one cycle after stb, with no AXI activity.
  - Return to IDLE once all outstanding handshakes, including the late response, have completed. Late response data is discarded.

Errors and read data:
- Each wb_err_o cycle pulses bridge_err_o and increments err_count_o, saturating at all-ones.
- wb_dat_o holds its last value between reads.

Latency with a zero-wait slave:
- Write: stb -> ack in 4 cycles (IDLE, ADDR, RESP, TERM).
- Read: also 4 cycles.

Test Plan:
- Write adr=0x00104, dat=0xDEADBEEF, sel=0xF, slave ready immediately -> aw/w both seen with those values, bresp=OKAY, wb_ack_o on cycle 4, no err, err_count_o=0.
- Write with awready 3 cycles after wvalid accepted -> awvalid stays high until then, wvalid deasserts after its own handshake, a single ack, no duplicate beats.
- Read adr=0x00200, slave returns rdata=0x12345678, rresp=SLVERR -> wb_err_o=1, wb_ack_o=0, wb_dat_o=0x12345678, bridge_err_o pulse, err_count_o=1.
- TIMEOUT_CYCLES=16, slave never asserts bvalid -> wb_err_o and timeout_o at cycle 17 after ADDR entry. A follow-up read gets wb_err_o with no arvalid. Then bvalid arrives -> bready handshake, IDLE, next read completes normally.
- 255 consecutive SLVERR reads plus 5 more with ERRCNT_BITS=8 -> err_count_o saturates at 255.
- aresetn pulled low during RESP of a read -> all outputs 0 immediately (asynchronous). After release, state is IDLE and a new write completes in 4 cycles.
